// File: rtl/uart_mmio_fifo_if.sv
// Bus and UART-core signal bundle for uart_mmio_fifo.
// Strobe semantics: write_enable, read_enable and rx_data_valid are single-cycle strobes that are always accepted.
// read_data is valid the cycle after read_enable and holds until the next read.
// tx_data_valid is a one-cycle start pulse, and the transmitter reports progress on tx_busy.
interface uart_mmio_fifo_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_enable;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  irq;
  logic [7:0]            rx_data;
  logic                  rx_data_valid;
  logic [7:0]            tx_data;
  logic                  tx_data_valid;
  logic                  tx_busy;

  modport slave (
    input  addr, write_data, write_enable, read_enable, rx_data, rx_data_valid, tx_busy,
    output read_data, irq, tx_data, tx_data_valid
  );

  modport master (
    output addr, write_data, write_enable, read_enable, rx_data, rx_data_valid, tx_busy,
    input  read_data, irq, tx_data, tx_data_valid
  );
endinterface

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART register block with TX/RX byte FIFOs, sticky error flags and a maskable irq.
// The TX FSM launches one byte per start pulse and waits out the transmitter before the next.
module uart_mmio_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16
) (
  input  logic               clk,
  input  logic               reset,
  uart_mmio_fifo_if.slave    bus,
  output logic [1:0]         tx_state_dbg
);
  localparam int TX_PW = $clog2(TX_DEPTH);
  localparam int RX_PW = $clog2(RX_DEPTH);
  localparam int TX_CW = TX_PW + 1;
  localparam int RX_CW = RX_PW + 1;
  localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
  localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_HOLD, S_WAIT} tx_state_e;

  tx_state_e             state_q, state_d;
  logic [TX_PW-1:0]      tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [RX_PW-1:0]      rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [TX_CW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [RX_CW-1:0]      rx_cnt_q, rx_cnt_d;
  logic                  rx_overrun_q, rx_overrun_d;
  logic                  tx_overflow_q, tx_overflow_d;
  logic [3:0]            ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  irq_q, irq_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_data_valid_q, tx_data_valid_d;
  logic [7:0]            tx_mem_q [TX_DEPTH];
  logic [7:0]            rx_mem_q [RX_DEPTH];

  logic [1:0]            reg_sel;
  logic                  rd_data_sel, wr_data_sel, wr_status_sel, wr_ctrl_sel;
  logic                  tx_empty, tx_full, rx_empty, rx_full, tx_idle;
  logic                  tx_pop, tx_push, tx_ovf_set;
  logic                  rx_take, rx_pop, rx_push, rx_ovr_set;
  logic [DATA_WIDTH-1:0] status_word;
  logic                  unused_bits;

  assign unused_bits = ^{bus.addr, bus.write_data};

  // Decode, FIFO occupancy and push/pop arbitration.
  always_comb begin
    reg_sel       = bus.addr[3:2];
    rd_data_sel   = bus.read_enable  && (reg_sel == 2'd1);
    wr_data_sel   = bus.write_enable && (reg_sel == 2'd1);
    wr_status_sel = bus.write_enable && (reg_sel == 2'd0);
    wr_ctrl_sel   = bus.write_enable && (reg_sel == 2'd2);
    tx_empty      = (tx_cnt_q == '0);
    tx_full       = (tx_cnt_q == TX_FULL_CNT);
    rx_empty      = (rx_cnt_q == '0);
    rx_full       = (rx_cnt_q == RX_FULL_CNT);
    tx_idle       = tx_empty && (state_q == S_IDLE) && !bus.tx_busy;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    tx_pop        = (state_q == S_SEND);
    tx_push       = wr_data_sel && (!tx_full || tx_pop);
    tx_ovf_set    = wr_data_sel && tx_full && !tx_pop;
    rx_pop        = rd_data_sel && !rx_empty;
    rx_take       = bus.rx_data_valid && ctrl_q[1];
    rx_push       = rx_take && (!rx_full || rx_pop);
    rx_ovr_set    = rx_take && rx_full && !rx_pop;

    tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + TX_PW'(1) : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + TX_PW'(1) : tx_rd_ptr_q;
    rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + RX_PW'(1) : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + RX_PW'(1) : rx_rd_ptr_q;

    tx_cnt_d = tx_cnt_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + TX_CW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - TX_CW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
    rx_cnt_d = rx_cnt_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + RX_CW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - RX_CW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  // Register file: sticky flags, control and the registered read port.
  always_comb begin
    status_word                 = '0;
    status_word[0]              = !rx_empty;
    status_word[1]              = tx_full;
    status_word[2]              = tx_idle;
    status_word[3]              = rx_overrun_q;
    status_word[4]              = tx_overflow_q;
    status_word[8 +: RX_CW]     = rx_cnt_q;
    status_word[16 +: TX_CW]    = tx_cnt_q;

    // Clear first so a same-cycle set wins.
    rx_overrun_d = rx_overrun_q;
    if (wr_status_sel && bus.write_data[3]) rx_overrun_d = 1'b0;
    if (rx_ovr_set)                          rx_overrun_d = 1'b1;
    tx_overflow_d = tx_overflow_q;
    if (wr_status_sel && bus.write_data[4]) tx_overflow_d = 1'b0;
    if (tx_ovf_set)                          tx_overflow_d = 1'b1;

    ctrl_d = wr_ctrl_sel ? bus.write_data[3:0] : ctrl_q;

    read_data_d = read_data_q;
    if (bus.read_enable) begin
      case (reg_sel)
        2'd0:    read_data_d = status_word;
        2'd1:    read_data_d = rx_empty ? '0 : DATA_WIDTH'(rx_mem_q[rx_rd_ptr_q]);
        2'd2:    read_data_d = DATA_WIDTH'(ctrl_q);
        default: read_data_d = '0;
      endcase
    end

    irq_d = (ctrl_q[2] && (!rx_empty || rx_overrun_q)) || (ctrl_q[3] && tx_empty);
  end

  // TX launcher: the start pulse is registered so it lines up with the SEND state.
  always_comb begin
    state_d         = state_q;
    tx_data_valid_d = 1'b0;
    tx_data_d       = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (!tx_empty && ctrl_q[0] && !bus.tx_busy) begin
          state_d         = S_SEND;
          tx_data_valid_d = 1'b1;
          tx_data_d       = tx_mem_q[tx_rd_ptr_q];
        end
      end
      S_SEND:  state_d = S_HOLD;
      S_HOLD:  state_d = S_WAIT;
      S_WAIT:  if (!bus.tx_busy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      tx_wr_ptr_q     <= '0;
      tx_rd_ptr_q     <= '0;
      rx_wr_ptr_q     <= '0;
      rx_rd_ptr_q     <= '0;
      tx_cnt_q        <= '0;
      rx_cnt_q        <= '0;
      rx_overrun_q    <= 1'b0;
      tx_overflow_q   <= 1'b0;
      ctrl_q          <= 4'b0011;
      read_data_q     <= '0;
      irq_q           <= 1'b0;
      tx_data_q       <= '0;
      tx_data_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      tx_wr_ptr_q     <= tx_wr_ptr_d;
      tx_rd_ptr_q     <= tx_rd_ptr_d;
      rx_wr_ptr_q     <= rx_wr_ptr_d;
      rx_rd_ptr_q     <= rx_rd_ptr_d;
      tx_cnt_q        <= tx_cnt_d;
      rx_cnt_q        <= rx_cnt_d;
      rx_overrun_q    <= rx_overrun_d;
      tx_overflow_q   <= tx_overflow_d;
      ctrl_q          <= ctrl_d;
      read_data_q     <= read_data_d;
      irq_q           <= irq_d;
      tx_data_q       <= tx_data_d;
      tx_data_valid_q <= tx_data_valid_d;
    end
  end

  // Storage needs no reset; the pointers and counts define the contents.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= bus.write_data[7:0];
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= bus.rx_data;
  end

  assign bus.read_data     = read_data_q;
  assign bus.irq           = irq_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_data_valid = tx_data_valid_q;
  assign tx_state_dbg      = state_q;
endmodule
